// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, deframes
// 11-bit packets with start/stop/odd-parity checking, and turns E0/F0-prefixed
// scan codes into held/press/release state for a configurable set of keys.
module ps2_key_decoder #(
  parameter int                    CLK_DIV       = 250,
  parameter int                    FILTER_LEN    = 4,
  parameter int                    TIMEOUT_TICKS = 4000,
  parameter int                    NUM_KEYS      = 4,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES     = {9'h175, 9'h172, 9'h174, 9'h16B}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [7:0]          rx_code,
  output logic                rx_valid,
  output logic                frame_error
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  logic             clkMeta_q, clkSync_q, dataMeta_q, dataSync_q;
  logic [DIV_W-1:0] divCnt_q;
  logic             tick;
  logic             filtClk_q, filtClk_d;
  logic [FLT_W-1:0] fltCnt_q, fltCnt_d;
  logic             fallEdge;

  state_t           state_q, state_d;
  logic [3:0]       bitCnt_q, bitCnt_d;
  logic [9:0]       shift_q, shift_d;
  logic [9:0]       frameBits;
  logic [TO_W-1:0]  toCnt_q, toCnt_d;
  logic [7:0]       rxCode_q, rxCode_d;
  logic             rxValid_q, rxValid_d;
  logic             frameErr_q, frameErr_d;

  logic                ext_q, ext_d;
  logic                brk_q, brk_d;
  logic [NUM_KEYS-1:0] keyDown_q, keyDown_d;
  logic [NUM_KEYS-1:0] keyPress_q, keyPress_d;
  logic [NUM_KEYS-1:0] keyRelease_q, keyRelease_d;

  // Two-flop synchronisers; idle level of both PS/2 lines is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clkMeta_q  <= 1'b1;
      clkSync_q  <= 1'b1;
      dataMeta_q <= 1'b1;
      dataSync_q <= 1'b1;
    end else begin
      clkMeta_q  <= ps2_clk;
      clkSync_q  <= clkMeta_q;
      dataMeta_q <= ps2_data;
      dataSync_q <= dataMeta_q;
    end
  end

  assign tick = (divCnt_q == DIV_W'(CLK_DIV - 1));

  // Sample-tick divider: one tick every CLK_DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) divCnt_q <= '0;
    else     divCnt_q <= tick ? '0 : divCnt_q + DIV_W'(1);
  end

  // Filtered clock follows the synchronised clock only after FILTER_LEN agreeing ticks.
  always_comb begin
    filtClk_d = filtClk_q;
    fltCnt_d  = fltCnt_q;
    if (tick) begin
      if (clkSync_q == filtClk_q) begin
        fltCnt_d = '0;
      end else if (fltCnt_q == FLT_W'(FILTER_LEN - 1)) begin
        filtClk_d = clkSync_q;
        fltCnt_d  = '0;
      end else begin
        fltCnt_d = fltCnt_q + FLT_W'(1);
      end
    end
  end

  assign fallEdge  = filtClk_q & ~filtClk_d;
  assign frameBits = {dataSync_q, shift_q[9:1]};

  // Glitch filter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filtClk_q <= 1'b1;
      fltCnt_q  <= '0;
    end else begin
      filtClk_q <= filtClk_d;
      fltCnt_q  <= fltCnt_d;
    end
  end

  // Deframer next state: start bit, 8 data bits LSB first, parity, stop, then check.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    toCnt_d    = toCnt_q;
    rxCode_d   = rxCode_q;
    rxValid_d  = 1'b0;
    frameErr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (fallEdge && !dataSync_q) begin
          state_d  = SHIFT;
          bitCnt_d = '0;
          shift_d  = '0;
          toCnt_d  = '0;
        end
      end
      SHIFT: begin
        if (fallEdge) begin
          shift_d = frameBits;
          toCnt_d = '0;
          if (bitCnt_q == 4'd9) begin
            state_d = CHECK;
            if (frameBits[9] && (^frameBits[8:0])) begin
              rxValid_d = 1'b1;
              rxCode_d  = frameBits[7:0];
            end else begin
              frameErr_d = 1'b1;
            end
          end else begin
            bitCnt_d = bitCnt_q + 4'd1;
          end
        end else if (tick) begin
          if (toCnt_q == TO_W'(TIMEOUT_TICKS - 1)) begin
            state_d    = IDLE;
            toCnt_d    = '0;
            frameErr_d = 1'b1;
          end else begin
            toCnt_d = toCnt_q + TO_W'(1);
          end
        end
      end
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Deframer state and receive result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      toCnt_q    <= '0;
      rxCode_q   <= '0;
      rxValid_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      toCnt_q    <= toCnt_d;
      rxCode_q   <= rxCode_d;
      rxValid_q  <= rxValid_d;
      frameErr_q <= frameErr_d;
    end
  end

  // Key decoder: prefixes set ext/brk, any other byte is matched then clears them.
  always_comb begin
    ext_d        = ext_q;
    brk_d        = brk_q;
    keyDown_d    = keyDown_q;
    keyPress_d   = '0;
    keyRelease_d = '0;
    if (frameErr_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rxValid_q) begin
      if (rxCode_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (rxCode_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        for (int i = 0; i < NUM_KEYS; i++) begin
          if ({ext_q, rxCode_q} == KEY_CODES[9*i +: 9]) begin
            if (brk_q) begin
              keyDown_d[i]    = 1'b0;
              keyRelease_d[i] = keyDown_q[i];
            end else begin
              keyDown_d[i]  = 1'b1;
              keyPress_d[i] = ~keyDown_q[i];
            end
          end
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  // Key state and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      keyDown_q    <= '0;
      keyPress_q   <= '0;
      keyRelease_q <= '0;
    end else begin
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      keyDown_q    <= keyDown_d;
      keyPress_q   <= keyPress_d;
      keyRelease_q <= keyRelease_d;
    end
  end

  assign key_down    = keyDown_q;
  assign key_press   = keyPress_q;
  assign key_release = keyRelease_q;
  assign rx_code     = rxCode_q;
  assign rx_valid    = rxValid_q;
  assign frame_error = frameErr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: table of whole frames with expected decode results,
// plus hand-written timeout, glitch and mid-frame reset sequences.
module tb_ps2_key_decoder;

  localparam int CLK_DIV       = 4;
  localparam int FILTER_LEN    = 2;
  localparam int TIMEOUT_TICKS = 40;
  localparam int NUM_KEYS      = 4;
  // PS/2 half period in clk cycles; a multiple of CLK_DIV keeps tick phase fixed.
  localparam int HALF          = 24;
  // Raw stop-bit fall to rx_valid: 2 sync flops, then FILTER_LEN ticks at fixed phase.
  localparam int EXP_LAT       = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                ps2Clk = 1'b1;
  logic                ps2Data = 1'b1;
  logic [NUM_KEYS-1:0] key_down, key_press, key_release;
  logic [7:0]          rx_code;
  logic                rx_valid, frame_error;

  typedef struct packed {
    logic [7:0] code;
    logic       badParity;
    logic       expErr;
    logic [7:0] expCode;
    logic [3:0] expDown;
    logic [3:0] expPress;
    logic [3:0] expRelease;
  } vec_t;

  vec_t vecs[$];

  int testsRun = 0;
  int testsFailed = 0;
  int validPulses = 0;
  int errPulses = 0;

  bit         seen;
  int         lat;
  logic       gotValid, gotErr;
  logic [7:0] gotCode;
  logic [3:0] gotDown, gotPress, gotRelease, pulseAfter;

  ps2_key_decoder #(
    .CLK_DIV      (CLK_DIV),
    .FILTER_LEN   (FILTER_LEN),
    .TIMEOUT_TICKS(TIMEOUT_TICKS),
    .NUM_KEYS     (NUM_KEYS),
    .KEY_CODES    ({9'h175, 9'h172, 9'h174, 9'h16B})
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2Clk),
    .ps2_data   (ps2Data),
    .key_down   (key_down),
    .key_press  (key_press),
    .key_release(key_release),
    .rx_code    (rx_code),
    .rx_valid   (rx_valid),
    .frame_error(frame_error)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Count every rx_valid and frame_error pulse to catch spurious or doubled pulses.
  always @(negedge clk) begin
    if (rx_valid === 1'b1)    validPulses <= validPulses + 1;
    if (frame_error === 1'b1) errPulses   <= errPulses + 1;
  end

  // Hard time limit so a stuck run still ends.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: run exceeded time limit, tests=%0d failed=%0d", testsRun, testsFailed);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] makeFrame(input logic [7:0] code, input logic badParity);
    return {1'b1, (~^code) ^ badParity, code, 1'b0};
  endfunction

  // Drive the first nBits bits of a frame; record the first response after any fall.
  task automatic sendBits(input logic [10:0] frame, input int nBits);
    seen       = 1'b0;
    lat        = 0;
    pulseAfter = '0;
    for (int b = 0; b < nBits; b++) begin
      ps2Data = frame[b];
      waitCycles(HALF);
      ps2Clk = 1'b0;
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk);
        if (!seen && (rx_valid || frame_error)) begin
          seen     = 1'b1;
          lat      = k;
          gotValid = rx_valid;
          gotErr   = frame_error;
          gotCode  = rx_code;
        end else if (seen && k == lat + 1) begin
          gotDown    = key_down;
          gotPress   = key_press;
          gotRelease = key_release;
        end else if (seen && k == lat + 2) begin
          pulseAfter = key_press | key_release;
        end
      end
      ps2Clk = 1'b1;
    end
    ps2Data = 1'b1;
    waitCycles(HALF);
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    compare({tag, ".responded"}, 32'(seen), 32'd1);
    if (seen) begin
      compare({tag, ".latency"},    lat, EXP_LAT);
      compare({tag, ".rxValid"},    32'(gotValid), 32'(!v.expErr));
      compare({tag, ".frameError"}, 32'(gotErr), 32'(v.expErr));
      compare({tag, ".rxCode"},     32'(gotCode), 32'(v.expCode));
      compare({tag, ".keyDown"},    32'(gotDown), 32'(v.expDown));
      compare({tag, ".keyPress"},   32'(gotPress), 32'(v.expPress));
      compare({tag, ".keyRelease"}, 32'(gotRelease), 32'(v.expRelease));
      compare({tag, ".pulseWidth"}, 32'(pulseAfter), 32'd0);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    sendBits(makeFrame(v.code, v.badParity), 11);
    checkOutput(v, tag);
  endtask

  function automatic vec_t mkVec(input logic [7:0] code, input logic bad, input logic err,
                                 input logic [7:0] expCode, input logic [3:0] d,
                                 input logic [3:0] p, input logic [3:0] r);
    vec_t v;
    v.code       = code;
    v.badParity  = bad;
    v.expErr     = err;
    v.expCode    = expCode;
    v.expDown    = d;
    v.expPress   = p;
    v.expRelease = r;
    return v;
  endfunction

  task automatic addVec(input logic [7:0] code, input logic bad, input logic err,
                        input logic [7:0] expCode, input logic [3:0] d,
                        input logic [3:0] p, input logic [3:0] r);
    vecs.push_back(mkVec(code, bad, err, expCode, d, p, r));
  endtask

  initial begin
    int validBefore;
    int errBefore;
    int expValid;

    // key0=E0 6B, key1=E0 74, key2=E0 72, key3=E0 75
    addVec(8'h1C, 0, 0, 8'h1C, 4'b0000, 4'b0000, 4'b0000);
    addVec(8'hE0, 0, 0, 8'hE0, 4'b0000, 4'b0000, 4'b0000);
    addVec(8'h6B, 0, 0, 8'h6B, 4'b0001, 4'b0001, 4'b0000);
    addVec(8'hE0, 0, 0, 8'hE0, 4'b0001, 4'b0000, 4'b0000);
    addVec(8'h6B, 0, 0, 8'h6B, 4'b0001, 4'b0000, 4'b0000);
    addVec(8'hE0, 0, 0, 8'hE0, 4'b0001, 4'b0000, 4'b0000);
    addVec(8'hF0, 0, 0, 8'hF0, 4'b0001, 4'b0000, 4'b0000);
    addVec(8'h6B, 0, 0, 8'h6B, 4'b0000, 4'b0000, 4'b0001);
    addVec(8'h6B, 0, 0, 8'h6B, 4'b0000, 4'b0000, 4'b0000);
    addVec(8'hE0, 0, 0, 8'hE0, 4'b0000, 4'b0000, 4'b0000);
    addVec(8'h74, 0, 0, 8'h74, 4'b0010, 4'b0010, 4'b0000);
    addVec(8'hE0, 0, 0, 8'hE0, 4'b0010, 4'b0000, 4'b0000);
    addVec(8'h75, 0, 0, 8'h75, 4'b1010, 4'b1000, 4'b0000);
    addVec(8'hF0, 0, 0, 8'hF0, 4'b1010, 4'b0000, 4'b0000);
    addVec(8'hE0, 0, 0, 8'hE0, 4'b1010, 4'b0000, 4'b0000);
    addVec(8'h74, 0, 0, 8'h74, 4'b1000, 4'b0000, 4'b0010);
    addVec(8'hE0, 0, 0, 8'hE0, 4'b1000, 4'b0000, 4'b0000);
    addVec(8'h74, 1, 1, 8'hE0, 4'b1000, 4'b0000, 4'b0000);
    addVec(8'h74, 0, 0, 8'h74, 4'b1000, 4'b0000, 4'b0000);
    addVec(8'hE0, 0, 0, 8'hE0, 4'b1000, 4'b0000, 4'b0000);
    addVec(8'h74, 0, 0, 8'h74, 4'b1010, 4'b0010, 4'b0000);
    addVec(8'hE0, 0, 0, 8'hE0, 4'b1010, 4'b0000, 4'b0000);
    addVec(8'h72, 0, 0, 8'h72, 4'b1110, 4'b0100, 4'b0000);
    addVec(8'hE0, 0, 0, 8'hE0, 4'b1110, 4'b0000, 4'b0000);
    addVec(8'hF0, 0, 0, 8'hF0, 4'b1110, 4'b0000, 4'b0000);
    addVec(8'h72, 0, 0, 8'h72, 4'b1010, 4'b0000, 4'b0100);
    addVec(8'hF0, 0, 0, 8'hF0, 4'b1010, 4'b0000, 4'b0000);
    addVec(8'hE0, 0, 0, 8'hE0, 4'b1010, 4'b0000, 4'b0000);
    addVec(8'h72, 0, 0, 8'h72, 4'b1010, 4'b0000, 4'b0000);
    addVec(8'hF0, 0, 0, 8'hF0, 4'b1010, 4'b0000, 4'b0000);
    addVec(8'h1C, 0, 0, 8'h1C, 4'b1010, 4'b0000, 4'b0000);
    addVec(8'hE0, 0, 0, 8'hE0, 4'b1010, 4'b0000, 4'b0000);
    addVec(8'h75, 0, 0, 8'h75, 4'b1010, 4'b0000, 4'b0000);

    // Reset state, during and after reset.
    rst = 1'b1;
    waitCycles(4);
    compare("reset.during", {key_down, key_press, key_release, rx_code, rx_valid, frame_error}, '0);
    rst = 1'b0;
    waitCycles(8);
    compare("reset.after", {key_down, key_press, key_release, rx_code, rx_valid, frame_error}, '0);

    // Table-driven frames.
    validBefore = validPulses;
    expValid    = 0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      if (!vecs[i].expErr) expValid++;
    end
    compare("table.validPulseCount", validPulses - validBefore, expValid);

    // Timeout: E0 then a frame that stops after 5 data bits; ext must be dropped.
    applyStimulus(mkVec(8'hE0, 0, 0, 8'hE0, 4'b1010, 4'b0000, 4'b0000), "timeout.prefix");
    errBefore   = errPulses;
    validBefore = validPulses;
    sendBits(makeFrame(8'h6B, 1'b0), 6);
    waitCycles(200);
    compare("timeout.errPulses", errPulses - errBefore, 1);
    compare("timeout.noValid", validPulses - validBefore, 0);
    applyStimulus(mkVec(8'h6B, 0, 0, 8'h6B, 4'b1010, 4'b0000, 4'b0000), "timeout.extCleared");
    applyStimulus(mkVec(8'h29, 0, 0, 8'h29, 4'b1010, 4'b0000, 4'b0000), "timeout.next");

    // One-tick glitch on ps2_clk while data is low must not start a frame.
    errBefore   = errPulses;
    validBefore = validPulses;
    ps2Data = 1'b0;
    waitCycles(HALF);
    ps2Clk = 1'b0;
    waitCycles(CLK_DIV);
    ps2Clk = 1'b1;
    waitCycles(HALF);
    ps2Data = 1'b1;
    waitCycles(HALF);
    compare("glitch.noError", errPulses - errBefore, 0);
    compare("glitch.noValid", validPulses - validBefore, 0);
    applyStimulus(mkVec(8'h29, 0, 0, 8'h29, 4'b1010, 4'b0000, 4'b0000), "glitch.next");

    // Reset in the middle of a frame with keys held.
    sendBits(makeFrame(8'h29, 1'b0), 4);
    errBefore = errPulses;
    @(negedge clk);
    rst = 1'b1;
    #1;
    compare("midReset.keyDown", 32'(key_down), 32'd0);
    compare("midReset.rxCode", 32'(rx_code), 32'd0);
    compare("midReset.pulses", {key_press, key_release, rx_valid, frame_error}, '0);
    waitCycles(4);
    rst = 1'b0;
    waitCycles(200);
    compare("midReset.noError", errPulses - errBefore, 0);
    applyStimulus(mkVec(8'h29, 0, 0, 8'h29, 4'b0000, 4'b0000, 4'b0000), "midReset.next");
    applyStimulus(mkVec(8'hE0, 0, 0, 8'hE0, 4'b0000, 4'b0000, 4'b0000), "midReset.prefix");
    applyStimulus(mkVec(8'h6B, 0, 0, 8'h6B, 4'b0001, 4'b0001, 4'b0000), "midReset.press");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
